// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read/write/issue/scoreboard signal bundle of the multi-port register file.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg_num1, read_reg_num2, write_reg, issue_reg;
    logic [DATA_W-1:0] read_data1, read_data2, write_data;
    logic regwrite, issue_valid, pending1, pending2, init_busy;
    modport master (
        output read_reg_num1, read_reg_num2, write_reg, write_data, regwrite, issue_valid, issue_reg,
        input  read_data1, read_data2, pending1, pending2, init_busy
    );
    modport slave (
        input  read_reg_num1, read_reg_num2, write_reg, write_data, regwrite, issue_valid, issue_reg,
        output read_data1, read_data2, pending1, pending2, init_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read/1-write register file with pending scoreboard and self-init sequence.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic clock,
    input logic reset,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR = ZERO_REG != 0;
    localparam bit BP = BYPASS != 0;
    typedef enum logic {INIT, IDLE} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend, pend_nxt;
    logic init, wr_en, iss_en, z1, z2;
    assign init   = state == INIT;
    assign z1     = ZR && bus.read_reg_num1 == '0;
    assign z2     = ZR && bus.read_reg_num2 == '0;
    assign wr_en  = !init && bus.regwrite && !(ZR && bus.write_reg == '0);
    assign iss_en = !init && bus.issue_valid && !(ZR && bus.issue_reg == '0);
    always_ff @(posedge clock) begin
        state <= reset ? INIT : state_nxt;
        cnt   <= (reset || !init) ? '0 : cnt + 1'b1;
    end
    always_comb begin
        state_nxt = (init && cnt == ADDR_W'(DEPTH - 1)) ? IDLE : state;
    end
    always_ff @(posedge clock) begin
        if (init && !reset)
            mem[cnt] <= DATA_W'(cnt);
        else if (wr_en)
            mem[bus.write_reg] <= bus.write_data;
    end
    // issue is applied after the clear so a same-register collision ends pending
    always_comb begin
        pend_nxt = pend;
        if (wr_en)
            pend_nxt[bus.write_reg] = 1'b0;
        if (iss_en)
            pend_nxt[bus.issue_reg] = 1'b1;
    end
    always_ff @(posedge clock) begin
        if (reset)
            pend <= '0;
        else if (!init)
            pend <= pend_nxt;
    end
    assign bus.init_busy  = init;
    assign bus.read_data1 = (init || z1) ? '0 :
                            (BP && wr_en && bus.write_reg == bus.read_reg_num1) ? bus.write_data :
                            mem[bus.read_reg_num1];
    assign bus.read_data2 = (init || z2) ? '0 :
                            (BP && wr_en && bus.write_reg == bus.read_reg_num2) ? bus.write_data :
                            mem[bus.read_reg_num2];
    assign bus.pending1   = !init && !z1 && pend[bus.read_reg_num1];
    assign bus.pending2   = !init && !z2 && pend[bus.read_reg_num2];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of a default instance and a small BYPASS=0 instance.
module tb_reg_file_mp;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int c0, c1;
    always #5 clock = ~clock;
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3)) b1 ();
    reg_file_mp #(.DATA_W(32), .ADDR_W(5)) u0 (.clock(clock), .reset(reset), .bus(b0.slave));
    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u1 (.clock(clock), .reset(reset), .bus(b1.slave));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    initial begin
        b0.read_reg_num1 = 5'd7;  b0.read_reg_num2 = 5'd31; b0.write_reg = 5'd7; b0.write_data = 32'hAAAA_AAAA;
        b0.regwrite = 1'b0; b0.issue_valid = 1'b0; b0.issue_reg = 5'd3;
        b1.read_reg_num1 = 3'd7;  b1.read_reg_num2 = 3'd3;  b1.write_reg = 3'd7; b1.write_data = 16'hAAAA;
        b1.regwrite = 1'b0; b1.issue_valid = 1'b0; b1.issue_reg = 3'd3;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", 32'(b0.init_busy), 32'd1);
        chk("rst_rd1", b0.read_data1, 32'd0);
        chk("rst_pend", 32'(b0.pending2), 32'd0);
        // Partial INIT with writes/issues asserted, then reset mid-INIT.
        reset = 1'b0;
        b0.regwrite = 1'b1; b0.issue_valid = 1'b1;
        b1.regwrite = 1'b1; b1.issue_valid = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        chk("mid_busy", 32'(b0.init_busy), 32'd1);
        chk("mid_rd", b0.read_data1, 32'd0);
        chk("mid_pend", 32'(b0.pending1), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 40; i++) begin
            c0 += int'(b0.init_busy);
            c1 += int'(b1.init_busy);
            b0.regwrite = b0.init_busy; b0.issue_valid = b0.init_busy;
            b1.regwrite = b1.init_busy; b1.issue_valid = b1.init_busy;
            @(negedge clock);
        end
        b0.regwrite = 1'b0; b0.issue_valid = 1'b0;
        b1.regwrite = 1'b0; b1.issue_valid = 1'b0;
        #1;
        chk("init_len0", c0, 32'd32);
        chk("init_len1", c1, 32'd8);
        chk("e7_u0", b0.read_data1, 32'h7);
        chk("e31_u0", b0.read_data2, 32'h1F);
        chk("e7_u1", b1.read_data1, 32'h7);
        chk("e3_u1", b1.read_data2, 32'h3);
        chk("pend3_u1", 32'(b1.pending2), 32'd0);
        b0.read_reg_num1 = 5'd0; b0.read_reg_num2 = 5'd3;
        #1;
        chk("e0_u0", b0.read_data1, 32'd0);
        chk("e3_u0", b0.read_data2, 32'h3);
        chk("pend3_u0", 32'(b0.pending2), 32'd0);
        // Write with same-cycle read of the target.
        @(negedge clock);
        b0.regwrite = 1'b1; b0.write_reg = 5'd5; b0.write_data = 32'hDEAD_BEEF; b0.read_reg_num1 = 5'd5; b0.read_reg_num2 = 5'd5;
        b1.regwrite = 1'b1; b1.write_reg = 3'd5; b1.write_data = 16'hBEEF; b1.read_reg_num1 = 3'd5;
        #1;
        chk("byp_u0", b0.read_data1, 32'hDEAD_BEEF);
        chk("byp2_u0", b0.read_data2, 32'hDEAD_BEEF);
        chk("nobyp_u1", b1.read_data1, 32'h5);
        @(negedge clock);
        b0.regwrite = 1'b0; b1.regwrite = 1'b0;
        #1;
        chk("wr_u0", b0.read_data1, 32'hDEAD_BEEF);
        chk("wr_u1", b1.read_data1, 32'hBEEF);
        chk("same_addr", b0.read_data2, 32'hDEAD_BEEF);
        // Zero register: write and issue both ignored.
        @(negedge clock);
        b0.regwrite = 1'b1; b0.write_reg = 5'd0; b0.write_data = 32'hFFFF_FFFF;
        b0.issue_valid = 1'b1; b0.issue_reg = 5'd0; b0.read_reg_num1 = 5'd0;
        b1.regwrite = 1'b1; b1.write_reg = 3'd0; b1.write_data = 16'hFFFF;
        b1.issue_valid = 1'b1; b1.issue_reg = 3'd0; b1.read_reg_num1 = 3'd0;
        #1;
        chk("z_byp_u0", b0.read_data1, 32'd0);
        @(negedge clock);
        b0.regwrite = 1'b0; b0.issue_valid = 1'b0;
        b1.regwrite = 1'b0; b1.issue_valid = 1'b0;
        #1;
        chk("z_rd_u0", b0.read_data1, 32'd0);
        chk("z_pend_u0", 32'(b0.pending1), 32'd0);
        chk("z_rd_u1", b1.read_data1, 32'd0);
        chk("z_pend_u1", 32'(b1.pending1), 32'd0);
        // Pending scoreboard: set, set-vs-clear collision, then clear.
        @(negedge clock);
        b0.issue_valid = 1'b1; b0.issue_reg = 5'd9; b0.read_reg_num1 = 5'd9;
        b1.issue_valid = 1'b1; b1.issue_reg = 3'd6; b1.read_reg_num1 = 3'd6;
        #1;
        chk("iss_pre_u0", 32'(b0.pending1), 32'd0);
        @(negedge clock);
        b0.issue_valid = 1'b0; b1.issue_valid = 1'b0;
        #1;
        chk("iss_u0", 32'(b0.pending1), 32'd1);
        chk("iss_u1", 32'(b1.pending1), 32'd1);
        @(negedge clock);
        b0.issue_valid = 1'b1; b0.regwrite = 1'b1; b0.write_reg = 5'd9; b0.write_data = 32'h1111;
        b1.issue_valid = 1'b1; b1.regwrite = 1'b1; b1.write_reg = 3'd6; b1.write_data = 16'h1111;
        @(negedge clock);
        b0.issue_valid = 1'b0; b1.issue_valid = 1'b0;
        b0.write_data = 32'h1234; b1.write_data = 16'h1234;
        #1;
        chk("coll_u0", 32'(b0.pending1), 32'd1);
        chk("coll_u1", 32'(b1.pending1), 32'd1);
        chk("clr_same_cyc", 32'(b0.pending1), 32'd1);
        @(negedge clock);
        b0.regwrite = 1'b0; b1.regwrite = 1'b0;
        #1;
        chk("clr_u0", 32'(b0.pending1), 32'd0);
        chk("clr_u1", 32'(b1.pending1), 32'd0);
        chk("clr_rd_u0", b0.read_data1, 32'h1234);
        chk("clr_rd_u1", b1.read_data1, 32'h1234);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
